// File: rtl/pwr_domain_seq.sv
// Power-domain sequencer: walks a switchable domain through isolate, save,
// switch-off, switch-on, settle, restore and de-isolate, watching a
// synchronised power-good from the switch. All outputs are registered.
//
// Handshake: pwr_down_req_i / pwr_up_req_i are levels, sampled only in ON
// (down alone) and OFF (up alone); anything else, in any other state, is
// ignored, and a level still high when ON/OFF is reached is taken then.
module pwr_domain_seq #(
  parameter int ISO_CYC    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int PGOOD_TO   = 64,
  parameter int RST_ON     = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwr_down_req_i,
  input  logic       pwr_up_req_i,
  input  logic       pgood_i,
  output logic       psw_en_o,
  output logic       iso_en_o,
  output logic       save_o,
  output logic       restore_o,
  output logic       dom_rst_o,
  output logic       on_o,
  output logic       off_o,
  output logic       timeout_o,
  output logic [3:0] dbg_state_o
);

  localparam logic [3:0] S_ON      = 4'd0;
  localparam logic [3:0] S_ISO     = 4'd1;
  localparam logic [3:0] S_SAVE    = 4'd2;
  localparam logic [3:0] S_PSW_OFF = 4'd3;
  localparam logic [3:0] S_OFF     = 4'd4;
  localparam logic [3:0] S_PSW_ON  = 4'd5;
  localparam logic [3:0] S_SETTLE  = 4'd6;
  localparam logic [3:0] S_RESTORE = 4'd7;
  localparam logic [3:0] S_DEISO   = 4'd8;

  localparam logic [3:0] S_RESET     = (RST_ON != 0) ? S_ON : S_OFF;
  // Counter is 0 in the first cycle of a state, so "N cycles" ends at N-1.
  localparam logic [9:0] ISO_LAST    = 10'(ISO_CYC - 1);
  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYC - 1);
  localparam logic [9:0] TO_LAST     = 10'(PGOOD_TO - 1);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [9:0] cnt_q;
  logic       pg_meta_q;
  logic       pg_s_q;
  logic       timeout_d;
  logic       down_req;
  logic       up_req;

  // Output bundle order: {psw, iso, save, restore, dom_rst, on, off}.
  function automatic logic [6:0] decode(input logic [3:0] s);
    logic [6:0] o;
    o = 7'b0100101;
    case (s)
      S_ON:      o = 7'b1000010;
      S_ISO:     o = 7'b1100000;
      S_SAVE:    o = 7'b1110000;
      S_PSW_OFF: o = 7'b0100100;
      S_OFF:     o = 7'b0100101;
      S_PSW_ON:  o = 7'b1100100;
      S_SETTLE:  o = 7'b1100100;
      S_RESTORE: o = 7'b1101000;
      S_DEISO:   o = 7'b1100000;
      default:   o = 7'b0100101;
    endcase
    return o;
  endfunction

  assign down_req    = pwr_down_req_i & ~pwr_up_req_i;
  assign up_req      = pwr_up_req_i & ~pwr_down_req_i;
  assign dbg_state_o = state_q;

  // Two-flop synchroniser for the asynchronous power-good.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pg_meta_q <= 1'b0;
      pg_s_q    <= 1'b0;
    end else begin
      pg_meta_q <= pgood_i;
      pg_s_q    <= pg_meta_q;
    end
  end

  // Next-state and sticky-timeout decision.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_o;
    case (state_q)
      S_ON: begin
        if (down_req) begin
          state_d   = S_ISO;
          timeout_d = 1'b0;
        end
      end
      S_ISO: begin
        if (cnt_q == ISO_LAST) state_d = S_SAVE;
      end
      S_SAVE: state_d = S_PSW_OFF;
      S_PSW_OFF: begin
        if (!pg_s_q) begin
          state_d = S_OFF;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_OFF;
          timeout_d = 1'b1;
        end
      end
      S_OFF: begin
        if (up_req) begin
          state_d   = S_PSW_ON;
          timeout_d = 1'b0;
        end
      end
      S_PSW_ON: begin
        if (pg_s_q) begin
          state_d = S_SETTLE;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_OFF;
          timeout_d = 1'b1;
        end
      end
      S_SETTLE: begin
        // A power-good drop while settling is treated as a failed power-up.
        if (!pg_s_q) begin
          state_d   = S_OFF;
          timeout_d = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_RESTORE;
        end
      end
      S_RESTORE: state_d = S_DEISO;
      S_DEISO: begin
        if (cnt_q == ISO_LAST) state_d = S_ON;
      end
      default: state_d = S_RESET;
    endcase
  end

  // State, shared saturating wait counter and timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_RESET;
      cnt_q     <= 10'd0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_o <= timeout_d;
      if (state_d != state_q) begin
        cnt_q <= 10'd0;
      end else if (cnt_q != 10'h3FF) begin
        cnt_q <= cnt_q + 10'd1;
      end
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {psw_en_o, iso_en_o, save_o, restore_o, dom_rst_o, on_o, off_o} <= decode(S_RESET);
    end else begin
      {psw_en_o, iso_en_o, save_o, restore_o, dom_rst_o, on_o, off_o} <= decode(state_d);
    end
  end

endmodule

// File: tb/tb_pwr_domain_seq.sv
// Bench for pwr_domain_seq: two instances (RST_ON=0 as index 0, RST_ON=1 as
// index 1) share clock, reset and requests; each has its own power switch
// responder. A timestamp-based phase model predicts all outputs each cycle.
module tb_pwr_domain_seq;
  localparam int ISO_CYC    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int PGOOD_TO   = 64;
  localparam int W          = 8;
  localparam int SIG_OFF = 0, SIG_ON = 1, SIG_RESTORE = 2;

  typedef enum int {P_ON, P_ISO, P_SAVE, P_PSW_OFF, P_OFF, P_PSW_ON,
                    P_SETTLE, P_RESTORE, P_DEISO} phase_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i;
  logic       down;
  logic       up;
  logic [1:0] pgood;
  logic [1:0] psw, iso, save, restore, drst, on, off, to;
  logic [3:0] dbg0, dbg1;

  pwr_domain_seq #(.ISO_CYC(ISO_CYC), .SETTLE_CYC(SETTLE_CYC), .PGOOD_TO(PGOOD_TO), .RST_ON(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .pwr_down_req_i(down), .pwr_up_req_i(up), .pgood_i(pgood[0]),
    .psw_en_o(psw[0]), .iso_en_o(iso[0]), .save_o(save[0]), .restore_o(restore[0]),
    .dom_rst_o(drst[0]), .on_o(on[0]), .off_o(off[0]), .timeout_o(to[0]), .dbg_state_o(dbg0));

  pwr_domain_seq #(.ISO_CYC(ISO_CYC), .SETTLE_CYC(SETTLE_CYC), .PGOOD_TO(PGOOD_TO), .RST_ON(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .pwr_down_req_i(down), .pwr_up_req_i(up), .pgood_i(pgood[1]),
    .psw_en_o(psw[1]), .iso_en_o(iso[1]), .save_o(save[1]), .restore_o(restore[1]),
    .dom_rst_o(drst[1]), .on_o(on[1]), .off_o(off[1]), .timeout_o(to[1]), .dbg_state_o(dbg1));

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- power switch responder ----------------
  int          pg_mode[2];      // 0: follow psw after pg_dly, 1: stuck low
  int          pg_dly[2];
  int          glitch_left[2];
  logic [15:0] psw_h[2];

  initial begin
    pgood = 2'b00;
    for (int i = 0; i < 2; i++) begin
      pg_mode[i] = 0; pg_dly[i] = 3; glitch_left[i] = 0; psw_h[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        psw_h[i] = {psw_h[i][14:0], psw[i] === 1'b1};
        if (glitch_left[i] > 0) begin
          pgood[i] = 1'b0;
          glitch_left[i]--;
        end else if (pg_mode[i] == 1) begin
          pgood[i] = 1'b0;
        end else begin
          pgood[i] = psw_h[i][pg_dly[i]-1];
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  phase_t m_ph[2];
  int     m_t[2];
  logic   m_to[2];
  logic   m_h0[2];
  logic   m_h1[2];
  int     cyc = 0;
  bit     model_on = 0;
  logic [2*W-1:0] exp_q[$];

  function automatic logic [W-1:0] exp_vec(input int i);
    logic [6:0] b;
    case (m_ph[i])
      P_ON:      b = 7'b1000010;
      P_ISO:     b = 7'b1100000;
      P_SAVE:    b = 7'b1110000;
      P_PSW_OFF: b = 7'b0100100;
      P_OFF:     b = 7'b0100101;
      P_PSW_ON:  b = 7'b1100100;
      P_SETTLE:  b = 7'b1100100;
      P_RESTORE: b = 7'b1101000;
      default:   b = 7'b1100000;
    endcase
    return {b, m_to[i]};
  endfunction

  task automatic model_step(input int i);
    logic   pg;
    int     n;
    phase_t nx;
    pg = m_h1[i];
    m_h1[i] = m_h0[i];
    m_h0[i] = pgood[i];
    n  = cyc - m_t[i];
    nx = m_ph[i];
    if (rst_i === 1'b1) begin
      m_h0[i] = 1'b0; m_h1[i] = 1'b0; m_to[i] = 1'b0;
      m_ph[i] = (i == 1) ? P_ON : P_OFF;
      m_t[i]  = cyc;
      return;
    end
    case (m_ph[i])
      P_ON:      if (down && !up) begin nx = P_ISO; m_to[i] = 1'b0; end
      P_ISO:     if (n >= ISO_CYC) nx = P_SAVE;
      P_SAVE:    nx = P_PSW_OFF;
      P_PSW_OFF: if (!pg) nx = P_OFF;
                 else if (n >= PGOOD_TO) begin nx = P_OFF; m_to[i] = 1'b1; end
      P_OFF:     if (up && !down) begin nx = P_PSW_ON; m_to[i] = 1'b0; end
      P_PSW_ON:  if (pg) nx = P_SETTLE;
                 else if (n >= PGOOD_TO) begin nx = P_OFF; m_to[i] = 1'b1; end
      P_SETTLE:  if (!pg) begin nx = P_OFF; m_to[i] = 1'b1; end
                 else if (n >= SETTLE_CYC) nx = P_RESTORE;
      P_RESTORE: nx = P_DEISO;
      default:   if (n >= ISO_CYC) nx = P_ON;
    endcase
    if (nx != m_ph[i]) begin
      m_ph[i] = nx;
      m_t[i]  = cyc;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_i === 1'b1) model_on = 1;
      if (model_on) begin
        model_step(0);
        model_step(1);
        exp_q.push_back({exp_vec(1), exp_vec(0)});
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    logic [2*W-1:0] e;
    logic [W-1:0]   act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 2; i++) begin
          act = {psw[i], iso[i], save[i], restore[i], drst[i], on[i], off[i], to[i]};
          check($sformatf("cyc%0d_inst%0d_outs", cyc, i), act, e[i*W +: W]);
        end
      end
    end
  end

  // Restore watcher for the reset-in-settle case.
  bit watch_r0 = 0;
  bit r0_seen  = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (watch_r0 && restore[0] === 1'b1) r0_seen = 1;
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic get_sig(input int sel, input int i);
    case (sel)
      SIG_OFF: return off[i];
      SIG_ON:  return on[i];
      default: return restore[i];
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sig(input string name, input int sel, input int i, input int budget);
    int k = 0;
    while (get_sig(sel, i) !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, get_sig(sel, i), 1'b1);
  endtask

  task automatic wait_phase(input string name, input int i, input phase_t p, input int budget);
    int k = 0;
    while (m_ph[i] != p && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, m_ph[i] == p, 1'b1);
  endtask

  task automatic pulse_down_both_off();
    down = 1'b1;
    step(1);
    down = 1'b0;
    wait_sig("down_inst1_off", SIG_OFF, 1, 200);
    wait_sig("down_inst0_off", SIG_OFF, 0, 200);
  endtask

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit stable;
    rst_i = 1'b1; down = 1'b0; up = 1'b0;
    step(3);
    rst_i = 1'b0;

    // Post-reset values: {psw, iso, dom_rst, on, off, timeout, save, restore}.
    check("reset_inst1", {psw[1], iso[1], drst[1], on[1], off[1], to[1], save[1], restore[1]}, 8'b10010000);
    check("reset_inst0", {psw[0], iso[0], drst[0], on[0], off[0], to[0], save[0], restore[0]}, 8'b01101000);

    // Both requests high: no movement in ON or OFF.
    down = 1'b1; up = 1'b1; stable = 1;
    repeat (100) begin
      step(1);
      if (!(on[1] === 1'b1 && off[0] === 1'b1)) stable = 0;
    end
    check("both_req_no_change", stable, 1'b1);
    down = 1'b0; up = 1'b0;
    step(2);

    // One-cycle down pulse, pgood falls 5 cycles after psw drops.
    pg_dly[0] = 5; pg_dly[1] = 5;
    step(8);
    down = 1'b1;
    step(1);
    down = 1'b0;
    check("iso_plus1", iso[1], 1'b1);
    step(3);
    check("save_not_at_plus4", save[1], 1'b0);
    step(1);
    check("save_at_plus5", save[1], 1'b1);
    step(1);
    check("save_single_cycle", {save[1], psw[1]}, 2'b00);
    wait_sig("down_reaches_off", SIG_OFF, 1, 200);
    check("down_no_timeout", to[1], 1'b0);

    // Power up, pgood rises 10 cycles after psw.
    pg_dly[0] = 10; pg_dly[1] = 10;
    step(2);
    up = 1'b1;
    wait_sig("restore_pulse", SIG_RESTORE, 1, 200);
    check("restore_with_drst_low", drst[1], 1'b0);
    step(4);
    check("iso_held_in_deiso", iso[1], 1'b1);
    step(1);
    check("iso_released_on", {iso[1], on[1]}, 2'b01);
    up = 1'b0;
    wait_sig("up_inst0_on", SIG_ON, 0, 50);

    // pgood stuck low during power-up.
    pulse_down_both_off();
    pg_mode[0] = 1; pg_mode[1] = 1;
    step(2);
    up = 1'b1;
    step(1);
    step(63);
    check("psw_still_on_c64", {psw[1], to[1]}, 2'b10);
    up = 1'b0;
    step(1);
    check("stuck_timeout_inst1", {off[1], psw[1], to[1]}, 3'b101);
    check("stuck_timeout_inst0", {off[0], psw[0], to[0]}, 3'b101);
    pg_mode[0] = 0; pg_mode[1] = 0; pg_dly[0] = 4; pg_dly[1] = 4;
    step(8);
    check("timeout_sticky", to[1], 1'b1);
    up = 1'b1;
    step(1);
    check("timeout_cleared_on_accept", to[1], 1'b0);
    wait_sig("retry_inst1_on", SIG_ON, 1, 200);
    up = 1'b0;
    wait_sig("retry_inst0_on", SIG_ON, 0, 50);

    // Reset during SETTLE on the RST_ON=0 instance.
    pulse_down_both_off();
    pg_dly[0] = 3; pg_dly[1] = 3;
    step(2);
    r0_seen = 0; watch_r0 = 1;
    up = 1'b1;
    wait_phase("reach_settle_inst0", 0, P_SETTLE, 200);
    step(2);
    rst_i = 1'b1; up = 1'b0;
    step(1);
    rst_i = 1'b0;
    check("rst_in_settle_off", {off[0], psw[0]}, 2'b10);
    check("rst_in_settle_inst1_on", on[1], 1'b1);
    step(20);
    watch_r0 = 0;
    check("no_restore_after_rst", r0_seen, 1'b0);

    // pgood glitch low for 3 cycles during SETTLE.
    down = 1'b1;
    step(1);
    down = 1'b0;
    wait_sig("glitch_prep_off", SIG_OFF, 1, 200);
    pg_dly[1] = 2;
    step(4);
    up = 1'b1;
    wait_phase("reach_settle_inst1", 1, P_SETTLE, 200);
    up = 1'b0;
    glitch_left[1] = 3;
    wait_sig("glitch_reaches_off", SIG_OFF, 1, 50);
    check("glitch_timeout", to[1], 1'b1);
    step(20);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) down = ~down;
      if ($urandom_range(0, 15) == 0) up = ~up;
      rst_i = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 79) == 0) glitch_left[i] = $urandom_range(1, 4);
        if ($urandom_range(0, 49) == 0) pg_dly[i] = $urandom_range(1, 12);
        if (pg_mode[i] == 0 && $urandom_range(0, 199) == 0) pg_mode[i] = 1;
        else if (pg_mode[i] == 1 && $urandom_range(0, 59) == 0) pg_mode[i] = 0;
      end
      step(1);
    end
    rst_i = 1'b0; down = 1'b0; up = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
